// File: rtl/pwm_driver.sv
// Dead-time complementary PWM gate driver with a 256-tick period and duty updates applied at period wrap.
// Gate outputs lag the raw compare by one clk plus a DEAD-clk blanking on every raw edge; there is no backpressure.
module pwm_driver #(
  parameter int DIV  = 4,
  parameter int DEAD = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] duty,
  input  logic       duty_valid,
  output logic       pwm_hi,
  output logic       pwm_lo,
  output logic       period_start,
  output logic [7:0] duty_active
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_HI_ON    = 2'd1;
  localparam logic [1:0] S_LO_ON    = 2'd2;
  localparam logic [1:0] S_DEADBAND = 2'd3;

  localparam logic [3:0] PRESC_MAX = 4'(DIV - 1);
  localparam logic [3:0] DEAD_LD   = 4'(DEAD);
  localparam logic       NO_DEAD   = (DEAD == 0);

  logic       en_q, en_d;
  logic [3:0] presc_q, presc_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] duty_active_q, duty_active_d;
  logic       period_start_q, period_start_d;
  logic       raw_q, raw_d;
  logic       raw_prev_q, raw_prev_d;
  logic [1:0] state_q, state_d;
  logic [3:0] dead_q, dead_d;

  logic       running;
  logic       rise;
  logic       tick;
  logic       wrap;
  logic       raw_chg;
  logic [7:0] next_duty;
  logic [1:0] level_state;

  always_comb begin
    running     = en_q && enable;
    rise        = enable && !en_q;
    tick        = running && (presc_q == PRESC_MAX);
    wrap        = tick && (cnt_q == 8'hFF);
    // A write landing on the update clk wins over the older pending value.
    next_duty   = duty_valid ? duty : pending_q;
    raw_chg     = (raw_q != raw_prev_q);
    level_state = raw_q ? S_HI_ON : S_LO_ON;

    en_d           = enable;
    presc_d        = presc_q;
    cnt_d          = cnt_q;
    pending_d      = duty_valid ? duty : pending_q;
    duty_active_d  = duty_active_q;
    period_start_d = 1'b0;
    raw_d          = running && (cnt_q < duty_active_q);
    raw_prev_d     = raw_q;
    state_d        = state_q;
    dead_d         = dead_q;

    if (!enable) begin
      presc_d = 4'd0;
      cnt_d   = 8'd0;
    end else if (rise) begin
      presc_d        = 4'd0;
      cnt_d          = 8'd0;
      duty_active_d  = next_duty;
      period_start_d = 1'b1;
    end else begin
      if (tick) begin
        presc_d = 4'd0;
        cnt_d   = cnt_q + 8'd1;
      end else begin
        presc_d = presc_q + 4'd1;
      end
      if (wrap) begin
        duty_active_d  = next_duty;
        period_start_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          if (NO_DEAD) begin
            state_d = level_state;
          end else begin
            state_d = S_DEADBAND;
            dead_d  = DEAD_LD;
          end
        end
      end
      S_HI_ON, S_LO_ON: begin
        if (level_state != state_q) begin
          if (NO_DEAD) begin
            state_d = level_state;
          end else begin
            state_d = S_DEADBAND;
            dead_d  = DEAD_LD;
          end
        end
      end
      default: begin
        // Another raw edge inside the blanking window restarts it.
        if (raw_chg) begin
          dead_d = DEAD_LD;
        end else if (dead_q <= 4'd1) begin
          dead_d  = 4'd0;
          state_d = level_state;
        end else begin
          dead_d = dead_q - 4'd1;
        end
      end
    endcase

    if (!enable) begin
      state_d = S_IDLE;
      dead_d  = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q           <= 1'b0;
      presc_q        <= 4'd0;
      cnt_q          <= 8'd0;
      pending_q      <= 8'd0;
      duty_active_q  <= 8'd0;
      period_start_q <= 1'b0;
      raw_q          <= 1'b0;
      raw_prev_q     <= 1'b0;
      state_q        <= S_IDLE;
      dead_q         <= 4'd0;
    end else begin
      en_q           <= en_d;
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      duty_active_q  <= duty_active_d;
      period_start_q <= period_start_d;
      raw_q          <= raw_d;
      raw_prev_q     <= raw_prev_d;
      state_q        <= state_d;
      dead_q         <= dead_d;
    end
  end

  // Outputs decode straight from the state flop, so the two gates can never overlap.
  assign pwm_hi       = (state_q == S_HI_ON);
  assign pwm_lo       = (state_q == S_LO_ON);
  assign period_start = period_start_q;
  assign duty_active  = duty_active_q;

endmodule

// File: tb/tb_pwm_driver.sv
// Checks pwm_driver (DIV=4 with DEAD=2, plus a DEAD=0 build) against a timeline model of period, duty and gate blanking.
module tb_pwm_driver;

  localparam int DIV  = 4;
  localparam int DEAD = 2;
  localparam int PER  = 256 * DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] duty;
  logic       duty_valid;
  logic       pwm_hi, pwm_lo, period_start;
  logic [7:0] duty_active;
  logic       hi0, lo0, ps0;
  logic [7:0] da0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pwm_driver #(.DIV(DIV), .DEAD(DEAD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .duty(duty), .duty_valid(duty_valid),
    .pwm_hi(pwm_hi), .pwm_lo(pwm_lo), .period_start(period_start), .duty_active(duty_active)
  );

  pwm_driver #(.DIV(DIV), .DEAD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .duty(duty), .duty_valid(duty_valid),
    .pwm_hi(hi0), .pwm_lo(lo0), .period_start(ps0), .duty_active(da0)
  );

  // Reference model: time since enable, period arithmetic, and a blanking window after each raw edge.
  int         m_t, m_cnt, m_cyc, m_last;
  bit         m_en, m_raw, m_ps;
  bit         m_hi, m_lo, m_hi0, m_lo0;
  logic [7:0] m_pend, m_da;

  task automatic model_reset();
    m_t = 0; m_cnt = 0; m_cyc = 0; m_last = -100;
    m_en = 0; m_raw = 0; m_ps = 0;
    m_hi = 0; m_lo = 0; m_hi0 = 0; m_lo0 = 0;
    m_pend = 8'h00; m_da = 8'h00;
  endtask

  task automatic model_edge();
    logic [7:0] nd;
    bit         new_raw, in_db;
    nd      = duty_valid ? duty : m_pend;
    new_raw = (m_en && enable) ? (m_cnt < int'(m_da)) : 1'b0;
    if (!enable) begin
      m_hi = 0; m_lo = 0; m_hi0 = 0; m_lo0 = 0;
    end else begin
      if (!m_en) m_last = m_cyc - 1;
      in_db = (m_cyc >= m_last + 1) && (m_cyc <= m_last + DEAD);
      m_hi  = !in_db && m_raw;
      m_lo  = !in_db && !m_raw;
      m_hi0 = m_raw;
      m_lo0 = !m_raw;
    end
    if (!enable) begin
      m_t = 0; m_cnt = 0; m_ps = 0;
    end else if (!m_en) begin
      m_t = 0; m_cnt = 0; m_da = nd; m_ps = 1;
    end else begin
      m_t   = m_t + 1;
      m_cnt = (m_t / DIV) % 256;
      m_ps  = (m_t % PER == 0);
      if (m_ps) m_da = nd;
    end
    if (duty_valid) m_pend = duty;
    if (new_raw != m_raw) m_last = m_cyc;
    m_raw = new_raw;
    m_en  = enable;
    m_cyc = m_cyc + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("pwm_hi", pwm_hi, m_hi);
    chk("pwm_lo", pwm_lo, m_lo);
    chk("no_overlap", pwm_hi & pwm_lo, 0);
    chk("period_start", period_start, m_ps);
    chk("duty_active", duty_active, m_da);
    chk("dead0_hi", hi0, m_hi0);
    chk("dead0_lo", lo0, m_lo0);
    chk("dead0_duty_active", da0, m_da);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all();
  endtask

  task automatic run_to_wrap();
    for (int k = 0; k < 2 * PER && (m_t % PER) != PER - 1; k++) step();
    step();
  endtask

  int hi_cnt, lo_cnt, ps_cnt;

  task automatic count_period();
    hi_cnt = 0; lo_cnt = 0; ps_cnt = 0;
    for (int k = 0; k < PER; k++) begin
      step();
      hi_cnt += int'(pwm_hi);
      lo_cnt += int'(pwm_lo);
      ps_cnt += int'(period_start);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; duty = 8'h00; duty_valid = 1'b0;
    model_reset();
    #3;
    check_all();
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Basic 0x40 run: 254 hi clks (256 minus blanking) and one period_start per 1024 clks.
    duty = 8'h40; duty_valid = 1'b1;
    step();
    duty_valid = 1'b0;
    enable = 1'b1;
    step();
    chk("rise_period_start", period_start, 1);
    count_period();
    chk("hi_per_period_40", hi_cnt, 254);
    chk("ps_per_period", ps_cnt, 1);
    chk("ps_after_1024", period_start, 1);

    // Mid-period writes only land at the wrap; the last of two writes wins.
    repeat (200) step();
    duty = 8'hC0; duty_valid = 1'b1; step(); duty_valid = 1'b0;
    repeat (20) step();
    chk("da_held_mid_period", duty_active, 8'h40);
    run_to_wrap();
    chk("da_after_wrap_c0", duty_active, 8'hC0);
    repeat (100) step();
    duty = 8'h80; duty_valid = 1'b1; step(); duty_valid = 1'b0;
    repeat (50) step();
    duty = 8'h20; duty_valid = 1'b1; step(); duty_valid = 1'b0;
    run_to_wrap();
    chk("da_last_write", duty_active, 8'h20);

    // Write coinciding with the wrap clk bypasses pending.
    for (int k = 0; k < 2 * PER && (m_t % PER) != PER - 1; k++) step();
    duty = 8'h99; duty_valid = 1'b1; step(); duty_valid = 1'b0;
    chk("da_bypass", duty_active, 8'h99);

    // Boundary duties.
    duty = 8'h00; duty_valid = 1'b1; step(); duty_valid = 1'b0;
    run_to_wrap();
    count_period();
    chk("hi_duty00", hi_cnt, 0);
    chk("lo_duty00", lo_cnt, PER);
    duty = 8'hFF; duty_valid = 1'b1; step(); duty_valid = 1'b0;
    run_to_wrap();
    count_period();
    chk("hi_dutyFF", hi_cnt, PER - 6);
    chk("lo_dutyFF", lo_cnt, 2);

    // Random duty writes.
    for (int k = 0; k < 6 * PER; k++) begin
      duty = 8'($urandom);
      duty_valid = ($urandom_range(0, 99) < 3);
      step();
    end
    duty_valid = 1'b0;

    // Drop enable at cnt=100, write while idle, then restart.
    for (int k = 0; k < 2 * PER && m_cnt != 100; k++) step();
    enable = 1'b0;
    step();
    chk("disable_hi", pwm_hi, 0);
    chk("disable_lo", pwm_lo, 0);
    duty = 8'h5A; duty_valid = 1'b1; step(); duty_valid = 1'b0;
    repeat (20) step();
    enable = 1'b1;
    step();
    chk("reenable_ps", period_start, 1);
    chk("reenable_da", duty_active, 8'h5A);
    ps_cnt = 0;
    for (int k = 0; k < PER - 1; k++) begin
      step();
      ps_cnt += int'(period_start);
    end
    chk("reenable_no_early_ps", ps_cnt, 0);
    step();
    chk("reenable_ps_at_1024", period_start, 1);

    // Random enable toggling together with random duty writes.
    for (int k = 0; k < 4000; k++) begin
      duty = 8'($urandom);
      duty_valid = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      step();
    end
    duty_valid = 1'b0;
    enable = 1'b1;
    duty = 8'h30; duty_valid = 1'b1; step(); duty_valid = 1'b0;

    // Reset asserted in the middle of a blanking window.
    run_to_wrap();
    step();
    step();
    chk("pre_reset_deadband", {pwm_hi, pwm_lo}, 2'b00);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("reset_da", duty_active, 8'h00);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("post_reset_ps", period_start, 1);
    chk("post_reset_da", duty_active, 8'h00);
    duty = 8'hA0; duty_valid = 1'b1; step(); duty_valid = 1'b0;
    run_to_wrap();
    repeat (300) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_driver.md
PWM_DRIVER -- requirements
Module: pwm_driver

Interface
REQ-001 SHALL have parameter DIV, default 4, meaning clk cycles per PWM tick (legal range 1..16).
REQ-002 SHALL have parameter DEAD, default 2, meaning dead-time in clk cycles (legal range 0..15).
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  run control; low stops and idles the PWM.
REQ-006 SHALL have port duty  input  8  unsigned duty request; its source is the 8-bit PID controller control_signal.
REQ-007 SHALL have port duty_valid  input  1  duty is sampled on every clk with duty_valid high.
REQ-008 SHALL have port pwm_hi  output  1  high-side gate drive.
REQ-009 SHALL have port pwm_lo  output  1  low-side gate drive, the complement of pwm_hi outside dead-time.
REQ-010 SHALL have port period_start  output  1  one-clk pulse at the start of each PWM period.
REQ-011 SHALL have port duty_active  output  8  duty value governing the current period.

Function
REQ-012 SHALL count a prescaler 0..DIV-1 while enable is high and raise an internal tick on each clk where the prescaler equals DIV-1, then wrap it to 0.
REQ-013 SHALL advance an 8-bit period counter cnt on each tick, wrapping 255->0, giving a period of 256*DIV clk cycles.
REQ-014 SHALL hold a pending register loaded from duty on every duty_valid clk; within one period, the last value written is the one retained.
REQ-015 SHALL copy pending into duty_active on the tick where cnt wraps 255->0; if duty_valid coincides with that tick, duty itself SHALL be copied (bypass).
REQ-016 SHALL never change duty_active mid-period (glitch-free update).
REQ-017 SHALL pulse period_start for exactly one clk on the clk where cnt becomes 0 from 255, and on the first clk after enable rises.
REQ-018 SHALL form a registered raw level: raw = (cnt < duty_active); duty_active 0 -> raw always low; 255 -> raw high 255 of 256 ticks.
REQ-019 SHALL implement a gate FSM with states IDLE, HI_ON, LO_ON, and DEADBAND, with outputs (pwm_hi, pwm_lo) = 00, 10, 01, and 00 respectively.
REQ-020 SHALL leave IDLE on enable high into DEADBAND.
REQ-021 SHALL enter DEADBAND and reload a dead counter with DEAD on a raw change in HI_ON or LO_ON.
REQ-022 SHALL reload the dead counter on a raw change while in DEADBAND (restart).
REQ-023 SHALL go from DEADBAND to HI_ON if raw=1, else to LO_ON, on the clk the dead counter reaches 0.
REQ-024 SHALL, with DEAD=0, bypass DEADBAND so outputs follow raw with one clk register latency.
REQ-025 SHALL never assert pwm_hi and pwm_lo simultaneously in any state or transition.
REQ-026 SHALL, on enable low, go to IDLE at the next clk: outputs 00, prescaler and cnt forced to 0, and no period_start.
REQ-027 SHALL retain pending while enable is low and still accept duty_valid.
REQ-028 SHALL, on enable rising, load duty_active from pending (or from duty if duty_valid coincides) and start at cnt=0.
REQ-029 SHALL treat all arithmetic as unsigned; no saturation is required because duty is already 8-bit clamped.

Reset
REQ-030 SHALL, with rst_n low, force immediately: pwm_hi=0, pwm_lo=0, period_start=0, duty_active=0x00, pending=0x00, cnt=0, prescaler=0, dead counter=0, FSM=IDLE.
REQ-031 SHALL, on rst_n deassertion with enable high, behave as an enable rising edge at the first clk.
REQ-032 SHALL, on rst_n assertion mid-period or mid-deadband, abort at once with both outputs low and no further pulses.

Verification
REQ-033 Bench SHALL cover: DIV=4, DEAD=2, duty=0x40 valid then enable -> pwm_hi high for 64 ticks minus deadband per 1024-clk period, period_start every 1024 clks.
REQ-034 Bench SHALL cover: duty 0x40 then 0xC0 written mid-period -> duty_active stays 0x40 until the wrap, then becomes 0xC0; with two writes in one period, only the last applies.
REQ-035 Bench SHALL cover: every raw edge -> exactly 2 clks of pwm_hi=pwm_lo=0, and a check at every clk that the outputs never equal 11.
REQ-036 Bench SHALL cover: duty=0x00 -> pwm_lo steady high, pwm_hi never high; duty=0xFF -> pwm_hi low for 1 tick per period (4 clks minus deadband handling).
REQ-037 Bench SHALL cover: enable dropped at cnt=100 -> outputs 00 next clk; enable raised -> period_start pulse, cnt restarts at 0, duty_active equals last pending.
REQ-038 Bench SHALL cover: rst_n pulsed low mid-deadband -> outputs 00 asynchronously and duty_active 0x00; DEAD=0 build -> outputs follow raw one clk later.
